// File: rtl/spi_regfile_slave_pkg.sv
// Shared definitions for the SPI register-file slave.
//   spi_state_e  : frame FSM states
//   SyncDepth    : flops in each input synchronizer
//   RwBitFromMsb : offset of the read/write flag from the command MSB
//   rw_bit_pos() : read/write flag position for a given word width
package spi_regfile_slave_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StHold
  } spi_state_e;

  localparam int unsigned SyncDepth    = 2;
  localparam int unsigned RwBitFromMsb = 0;

  function automatic int unsigned rw_bit_pos(input int unsigned width);
    return width - 1 - RwBitFromMsb;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection in the clk domain.
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous input
//   rise, fall   : one-clk pulses on synchronized edges of din
// Flops reset to IdleLevel so releasing reset never fakes an edge.
module spi_sync_edge
  import spi_regfile_slave_pkg::*;
#(
  parameter logic IdleLevel = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SyncDepth-1:0] sync_q;
  logic                 prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SyncDepth{IdleLevel}};
      prev_q <= IdleLevel;
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], din};
      prev_q <= sync_q[SyncDepth-1];
    end
  end

  assign rise = sync_q[SyncDepth-1] & ~prev_q;
  assign fall = ~sync_q[SyncDepth-1] & prev_q;

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI slave exposing a small register file, oversampled in the clk domain.
//   clk, reset_n   : system clock, async active-low reset
//   SCLK, MOSI, ss : SPI master signals (asynchronous, ss active low)
//   MISO           : slave data out, 0 when not in a command/data word
//   status_in      : read-only value returned for the top address
//   regs_out       : flattened registers, reg0 in the LSBs
//   wr_strobe      : one-clk pulse per completed write
//   rd_strobe      : one-clk pulse per completed read
//   last_addr      : address of the most recently decoded command
// Frame: command word (MSB = write flag, low bits = address) then data word.
module spi_regfile_slave
  import spi_regfile_slave_pkg::*;
#(
  parameter logic [1:0]  mode      = 2'b00,
  parameter int unsigned bits_size = 8,
  parameter int unsigned addr_bits = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                SCLK,
  input  logic                                MOSI,
  input  logic                                ss,
  output logic                                MISO,
  input  logic [bits_size-1:0]                status_in,
  output logic [(2**addr_bits)*bits_size-1:0] regs_out,
  output logic                                wr_strobe,
  output logic                                rd_strobe,
  output logic [addr_bits-1:0]                last_addr
);

  localparam int unsigned NumRegs = 2**addr_bits;
  localparam int unsigned CntW    = $clog2(bits_size);
  localparam int unsigned RwBit   = rw_bit_pos(bits_size);
  localparam logic        Cpol    = mode[1];
  localparam logic        Cpha    = mode[0];
  localparam logic [addr_bits-1:0] StatusAddr = {addr_bits{1'b1}};

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SyncDepth-1:0] mosi_sync_q;

  spi_sync_edge #(.IdleLevel(Cpol)) u_sync_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (SCLK),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_sync_edge #(.IdleLevel(1'b1)) u_sync_ss (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (ss),
    .rise   (ss_rise),
    .fall   (ss_fall)
  );

  // Same depth as the SCLK path, so MOSI is aligned with the detected edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_sync_q <= '0;
    else          mosi_sync_q <= {mosi_sync_q[SyncDepth-2:0], MOSI};
  end

  logic leading_edge, trailing_edge, sample_edge, drive_edge;
  assign leading_edge  = Cpol ? sclk_fall : sclk_rise;
  assign trailing_edge = Cpol ? sclk_rise : sclk_fall;
  assign sample_edge   = Cpha ? trailing_edge : leading_edge;
  assign drive_edge    = Cpha ? leading_edge : trailing_edge;

  spi_state_e                       state_q, state_d;
  logic [CntW-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [bits_size-2:0]             shift_in_q, shift_in_d;
  logic [bits_size-1:0]             shift_out_q, shift_out_d;
  logic                             miso_q, miso_d;
  logic                             is_write_q, is_write_d;
  logic [addr_bits-1:0]             addr_q, addr_d;
  logic [NumRegs-1:0][bits_size-1:0] regs_q, regs_d;
  logic                             wr_strobe_q, wr_strobe_d;
  logic                             rd_strobe_q, rd_strobe_d;

  logic [bits_size-1:0] word_next;
  logic [addr_bits-1:0] cmd_addr;
  logic [bits_size-1:0] rd_value;
  logic                 last_bit;

  assign word_next = {shift_in_q, mosi_sync_q[SyncDepth-1]};
  assign cmd_addr  = word_next[addr_bits-1:0];
  assign rd_value  = (cmd_addr == StatusAddr) ? status_in : regs_q[cmd_addr];
  assign last_bit  = (bit_cnt_q == CntW'(bits_size - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    miso_d      = miso_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d     = StCmd;
          bit_cnt_d   = '0;
          shift_in_d  = '0;
          shift_out_d = '0;
          miso_d      = 1'b0;
        end
      end
      StCmd, StData: begin
        if (ss_rise) begin
          state_d = StIdle;
        end else begin
          // shift_out holds the bits still to be presented; miso_q is the
          // bit currently on the wire. Loading the data word here means the
          // next drive edge presents its MSB in both CPHA settings.
          if (drive_edge) begin
            miso_d      = shift_out_q[bits_size-1];
            shift_out_d = shift_out_q << 1;
          end
          if (sample_edge) begin
            shift_in_d = word_next[bits_size-2:0];
            bit_cnt_d  = last_bit ? '0 : bit_cnt_q + CntW'(1);
            if (last_bit) begin
              if (state_q == StCmd) begin
                state_d     = StData;
                is_write_d  = word_next[RwBit];
                addr_d      = cmd_addr;
                shift_out_d = word_next[RwBit] ? '0 : rd_value;
              end else begin
                state_d = StHold;
                if (is_write_q) begin
                  wr_strobe_d = 1'b1;
                  if (addr_q != StatusAddr) regs_d[addr_q] = word_next;
                end else begin
                  rd_strobe_d = 1'b1;
                end
              end
            end
          end
        end
      end
      StHold: begin
        if (ss_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      miso_q      <= miso_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  assign MISO      = miso_q & ((state_q == StCmd) || (state_q == StData));
  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign last_addr = addr_q;

endmodule
